sevseg_scan_ctrl: RTL and testbench



---
 rtl/sevseg_scan_ctrl_if.sv | 10 +
 rtl/sevseg_scan_ctrl.sv | 106 ++++++++++
 tb/tb_sevseg_scan_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sevseg_scan_ctrl_if.sv
// sevseg_scan_ctrl_if: Avalon-MM-style register port for the 7-segment scan controller.
interface sevseg_scan_ctrl_if;
    logic [2:0] address;
    logic       write;
    logic [7:0] writedata;
    logic       read;
    logic [7:0] readdata;
    modport master (output address, write, writedata, read, input readdata);
    modport slave (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: register-mapped multiplexer of BCD digits onto one 7-segment decoder and a common-anode bus.
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYC    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    sevseg_scan_ctrl_if.slave     bus,
    output logic [6:0]            seven_seg,
    output logic [NUM_DIGITS-1:0] digit_en
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [4:0]       r_digit [NUM_DIGITS];
    logic [1:0]       r_ctrl;
    logic [7:0]       r_rdata, w_rdata;
    logic [6:0]       w_seg_tab [NUM_DIGITS];
    logic             w_ctrl_sel, w_dig_sel;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0011000;
            default: dec = 7'b1111111;
        endcase
    endfunction

    assign w_ctrl_sel   = bus.address == 3'd7;
    assign w_dig_sel    = !w_ctrl_sel && ({1'b0, bus.address} < 4'(NUM_DIGITS));
    assign w_rdata      = w_ctrl_sel ? {6'd0, r_ctrl} :
                          w_dig_sel  ? {3'd0, r_digit[bus.address[IDX_W-1:0]]} : 8'd0;
    assign bus.readdata = r_rdata;

    // A digit is suppressed only when it and every more-significant digit hold value 0.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            logic z;
            z = 1'b1;
            for (int j = k; j < NUM_DIGITS; j++) z = z & (r_digit[j][3:0] == 4'd0);
            w_seg_tab[k] = (r_digit[k][4] || (r_ctrl[1] && k > 0 && z)) ? 7'h7F : dec(r_digit[k][3:0]);
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = '0;
        w_idx   = r_idx;
        case (r_state)
            IDLE: begin
                w_idx   = '0;
                w_state = r_ctrl[0] ? SHOW : IDLE;
            end
            SHOW: begin
                if (r_cnt == CNT_W'(SCAN_DIV - 1)) w_state = GAP;
                else w_cnt = r_cnt + 1'b1;
            end
            GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_state = SHOW;
                    w_idx   = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
                end else w_cnt = r_cnt + 1'b1;
            end
            default: w_state = IDLE;
        endcase
        if (!r_ctrl[0]) begin
            w_state = IDLE;
            w_idx   = '0;
            w_cnt   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_ctrl    <= '0;
            r_rdata   <= '0;
            seven_seg <= 7'h7F;
            digit_en  <= '1;
            for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            seven_seg <= (w_state == SHOW) ? w_seg_tab[w_idx] : 7'h7F;
            digit_en  <= (w_state == SHOW) ? ~(NUM_DIGITS'(1) << w_idx) : '1;
            if (bus.read) r_rdata <= w_rdata;
            if (bus.write && w_ctrl_sel) r_ctrl <= bus.writedata[1:0];
            if (bus.write && w_dig_sel) r_digit[bus.address[IDX_W-1:0]] <= bus.writedata[4:0];
        end
    end
endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// tb_sevseg_scan_ctrl: directed checks of register access, scan timing, decode, suppression and disable.
module tb_sevseg_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seven_seg;
    logic [3:0] digit_en;
    logic [7:0] rdv;
    logic [6:0] exp_seg [4];
    int         errors = 0;
    int         checks = 0;

    sevseg_scan_ctrl_if bus();

    sevseg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .GAP_CYC(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .seven_seg(seven_seg), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        bus.address = a;
        bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic load(input logic [7:0] d0, d1, d2, d3, input logic [7:0] ctrl);
        wr(3'd7, 8'h00);
        wr(3'd0, d0);
        wr(3'd1, d1);
        wr(3'd2, d2);
        wr(3'd3, d3);
        wr(3'd7, ctrl);
    endtask

    // Each slot: 4 SHOW cycles then 1 all-off gap cycle, digits 0..3 in order.
    task automatic scan_chk(input string tag, input int n);
        logic [3:0] e;
        for (int t = 0; t < n; t++) begin
            tick();
            e = 4'hF;
            if (t % 5 < 4) e[(t / 5) % 4] = 1'b0;
            chk({tag, "_en"}, 32'(digit_en), 32'(e));
            chk({tag, "_seg"}, 32'(seven_seg), (t % 5 < 4) ? 32'(exp_seg[(t / 5) % 4]) : 32'h7F);
        end
    endtask

    initial begin
        bus.address = '0;
        bus.write = 1'b0;
        bus.writedata = '0;
        bus.read = 1'b0;
        tick();
        tick();
        chk("rst_seg", 32'(seven_seg), 32'h7F);
        chk("rst_en", 32'(digit_en), 32'hF);
        chk("rst_rdata", 32'(bus.readdata), 32'h0);
        reset = 1'b0;
        tick();
        wr(3'd7, 8'h01);
        tick();
        chk("pre_rst_show", 32'(digit_en), 32'hE);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_seg", 32'(seven_seg), 32'h7F);
        chk("async_rst_en", 32'(digit_en), 32'hF);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_seg", 32'(seven_seg), 32'h7F);
            chk("idle_en", 32'(digit_en), 32'hF);
        end
        rd(3'd7, rdv);
        chk("ctrl_after_rst", 32'(rdv), 32'h00);

        exp_seg = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        load(8'd1, 8'd2, 8'd3, 8'd4, 8'h01);
        scan_chk("scan", 40);

        exp_seg = '{7'b1111000, 7'h7F, 7'h7F, 7'h7F};
        load(8'd7, 8'd0, 8'd0, 8'd0, 8'h03);
        scan_chk("lzs7", 20);
        exp_seg = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
        load(8'd0, 8'd0, 8'd0, 8'd0, 8'h03);
        scan_chk("lzs0", 20);

        exp_seg = '{7'b1111001, 7'h7F, 7'b0110000, 7'b0011001};
        load(8'd1, 8'h0C, 8'd3, 8'd4, 8'h01);
        scan_chk("inval", 20);
        rd(3'd1, rdv);
        chk("rd_inval", 32'(rdv), 32'h0C);
        load(8'd1, 8'h15, 8'd3, 8'd4, 8'h01);
        scan_chk("fblank", 20);
        rd(3'd1, rdv);
        chk("rd_fblank", 32'(rdv), 32'h15);

        load(8'd1, 8'd2, 8'd3, 8'd4, 8'h01);
        repeat (12) tick();
        chk("slot2_show", 32'(digit_en), 32'hB);
        wr(3'd7, 8'h00);
        tick();
        chk("dis_seg", 32'(seven_seg), 32'h7F);
        chk("dis_en", 32'(digit_en), 32'hF);
        wr(3'd7, 8'h01);
        tick();
        chk("reen_en", 32'(digit_en), 32'hE);
        chk("reen_seg", 32'(seven_seg), 32'b1111001);

        wr(3'd5, 8'hFF);
        rd(3'd5, rdv);
        chk("rd_addr5", 32'(rdv), 32'h00);
        for (int a = 0; a < 4; a++) begin
            rd(3'(a), rdv);
            chk("rd_digit", 32'(rdv), 32'(a + 1));
        end
        rd(3'd7, rdv);
        chk("rd_ctrl", 32'(rdv), 32'h01);
        bus.address = 3'd2;
        bus.writedata = 8'h09;
        bus.write = 1'b1;
        bus.read = 1'b1;
        tick();
        bus.write = 1'b0;
        bus.read = 1'b0;
        chk("rw_old", 32'(bus.readdata), 32'h03);
        rd(3'd2, rdv);
        chk("rw_new", 32'(rdv), 32'h09);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
